// File: rtl/vcve2_pkg.sv
// Shared types and constants for the vector register file address path.
// No logic, so no latency and no backpressure.
// vlmul_e uses the RVV vlmul encoding: a 3-bit signed log2 of LMUL.
package vcve2_pkg;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [2:0] {
        AGU_IDLE,
        AGU_CALC_RS1,
        AGU_CALC_RS2,
        AGU_CALC_RD,
        AGU_READY
    } agu_state_t;

    localparam int unsigned NUM_VREGS    = 32;
    localparam int unsigned VLEN_DEFAULT = 128;

    function automatic int unsigned vrf_reg_bytes(input int unsigned vlen);
        return vlen / 8;
    endfunction

    localparam int unsigned VRF_REG_BYTES = vrf_reg_bytes(VLEN_DEFAULT);

endpackage

// File: rtl/vcve2_agu_ptr.sv
// One 32-bit byte-address pointer with load and step-increment; load wins over increment.
// Latency: a load or increment becomes visible on ptr_o the cycle after it is asserted.
// Backpressure: none; it updates whenever enabled.
module vcve2_agu_ptr #(
    parameter logic [31:0] Step = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        incr_i,
    output logic [31:0] ptr_o
);

    logic [31:0] ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 32'd0;
        end else if (load_i) begin
            ptr_q <= load_val_i;
        end else if (incr_i) begin
            ptr_q <= ptr_q + Step;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/vcve2_vrf_agu.sv
// VRF address generator: turns rs1/rs2/rd indices into byte addresses; VCVE2_AGU_RANGE_CHECK_EN adds the group range check.
// Latency: load_i in cycle 0 gives ready_o from cycle 4; vrf_addr_o is combinational from the get_* inputs.
// Backpressure: none; the requester waits on ready_o, and load_i restarts the sequence at any time.
module vcve2_vrf_agu
    import vcve2_pkg::*;
#(
    parameter int unsigned VLEN        = 128,
    parameter int unsigned PIPE_WIDTH  = 32,
    parameter int unsigned AddrWidth   = 5,
    parameter logic [31:0] VrfBaseAddr = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] rs1_idx_i,
    input  logic [AddrWidth-1:0] rs2_idx_i,
    input  logic [AddrWidth-1:0] rd_idx_i,
    input  vlmul_e               lmul_i,
    input  logic                 get_rs1_i,
    input  logic                 get_rs2_i,
    input  logic                 get_rd_i,
    input  logic                 incr_i,
    output logic                 ready_o,
    output logic [31:0]          vrf_addr_o,
    output logic                 range_err_o
);

    localparam int unsigned RegShift = $clog2(vrf_reg_bytes(VLEN));
    localparam logic [31:0] PtrStep  = 32'(PIPE_WIDTH / 8);

    agu_state_t           state_q, state_d;
    logic [AddrWidth-1:0] rs1_q, rs2_q, rd_q;
    logic [AddrWidth-1:0] calc_idx;
    logic [31:0]          calc_addr;
    logic                 calc_active;
    logic                 ld_rs1, ld_rs2, ld_rd;
    logic                 inc_ok, inc_rs1, inc_rs2, inc_rd;
    logic [31:0]          rs1_ptr, rs2_ptr, rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= AGU_IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load_i) begin
                rs1_q <= rs1_idx_i;
                rs2_q <= rs2_idx_i;
                rd_q  <= rd_idx_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = AGU_CALC_RS1;
        end else begin
            case (state_q)
                AGU_CALC_RS1: state_d = AGU_CALC_RS2;
                AGU_CALC_RS2: state_d = AGU_CALC_RD;
                AGU_CALC_RD:  state_d = AGU_READY;
                default:      state_d = state_q;
            endcase
        end
    end

    // One adder serves all three pointers; the CALC state picks which index feeds it.
    always_comb begin
        calc_idx    = '0;
        calc_active = 1'b0;
        case (state_q)
            AGU_CALC_RS1: begin calc_idx = rs1_q; calc_active = 1'b1; end
            AGU_CALC_RS2: begin calc_idx = rs2_q; calc_active = 1'b1; end
            AGU_CALC_RD:  begin calc_idx = rd_q;  calc_active = 1'b1; end
            default:      ;
        endcase
    end

    assign calc_addr = VrfBaseAddr + (32'(calc_idx) << RegShift);

    // A restarting load suppresses this cycle's pointer writes; the new sequence recomputes them.
    assign ld_rs1 = !load_i && (state_q == AGU_CALC_RS1);
    assign ld_rs2 = !load_i && (state_q == AGU_CALC_RS2);
    assign ld_rd  = !load_i && (state_q == AGU_CALC_RD);

    assign inc_ok  = !load_i && incr_i && (state_q == AGU_READY);
    assign inc_rs1 = inc_ok && get_rs1_i;
    assign inc_rs2 = inc_ok && !get_rs1_i && get_rs2_i;
    assign inc_rd  = inc_ok && !get_rs1_i && !get_rs2_i && get_rd_i;

    vcve2_agu_ptr #(.Step(PtrStep)) u_ptr_rs1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(ld_rs1), .load_val_i(calc_addr),
        .incr_i(inc_rs1), .ptr_o(rs1_ptr)
    );
    vcve2_agu_ptr #(.Step(PtrStep)) u_ptr_rs2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(ld_rs2), .load_val_i(calc_addr),
        .incr_i(inc_rs2), .ptr_o(rs2_ptr)
    );
    vcve2_agu_ptr #(.Step(PtrStep)) u_ptr_rd (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(ld_rd), .load_val_i(calc_addr),
        .incr_i(inc_rd), .ptr_o(rd_ptr)
    );

    assign ready_o = (state_q == AGU_READY);

    always_comb begin
        vrf_addr_o = 32'd0;
        if (ready_o) begin
            if (get_rs1_i)      vrf_addr_o = rs1_ptr;
            else if (get_rs2_i) vrf_addr_o = rs2_ptr;
            else if (get_rd_i)  vrf_addr_o = rd_ptr;
        end
    end

`ifdef VCVE2_AGU_RANGE_CHECK_EN
    vlmul_e      lmul_q;
    logic [31:0] grp_size;
    logic        calc_bad;
    logic        range_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lmul_q      <= LMUL_1;
            range_err_q <= 1'b0;
        end else if (load_i) begin
            lmul_q      <= lmul_i;
            range_err_q <= 1'b0;
        end else if (calc_active && calc_bad) begin
            range_err_q <= 1'b1;
        end
    end

    // Negative vlmul (fractional or reserved) occupies a single register.
    assign grp_size = lmul_q[2] ? 32'd1 : (32'd1 << lmul_q[1:0]);
    assign calc_bad = ((32'(calc_idx) + grp_size) > 32'(NUM_VREGS)) ||
                      ((32'(calc_idx) & (grp_size - 32'd1)) != 32'd0);
    assign range_err_o = range_err_q;
`else
    logic unused_lmul;
    logic unused_calc;
    assign unused_lmul = ^lmul_i;
    assign unused_calc = calc_active;
    assign range_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vcve2_vrf_agu.sv
// Directed and random checks of vcve2_vrf_agu against an arithmetic reference model.
module tb_vcve2_vrf_agu;
    import vcve2_pkg::*;

    localparam int unsigned VLEN       = 128;
    localparam int unsigned PIPE_WIDTH = 32;
    localparam int unsigned AW         = 5;
    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam int unsigned REG_BYTES  = VLEN / 8;
    localparam int unsigned STEP       = PIPE_WIDTH / 8;
    localparam int          RDY        = 3;
`ifdef VCVE2_AGU_RANGE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          load_i;
    logic [AW-1:0] rs1_idx_i, rs2_idx_i, rd_idx_i;
    vlmul_e        lmul_i;
    logic          get_rs1_i, get_rs2_i, get_rd_i, incr_i;
    logic          ready_o;
    logic [31:0]   vrf_addr_o;
    logic          range_err_o;

    int total = 0;
    int bad   = 0;

    // Reference model: m_cnt = -1 never loaded, 0..2 computing, RDY = ready.
    int unsigned m_ptr[3];
    int unsigned m_idx[3];
    vlmul_e      m_lmul;
    int          m_cnt;
    bit          m_err;

    vcve2_vrf_agu #(
        .VLEN(VLEN), .PIPE_WIDTH(PIPE_WIDTH), .AddrWidth(AW), .VrfBaseAddr(BASE)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(load_i),
        .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i), .rd_idx_i(rd_idx_i),
        .lmul_i(lmul_i), .get_rs1_i(get_rs1_i), .get_rs2_i(get_rs2_i), .get_rd_i(get_rd_i),
        .incr_i(incr_i), .ready_o(ready_o), .vrf_addr_o(vrf_addr_o), .range_err_o(range_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit grp_bad(input int unsigned idx, input vlmul_e l);
        int lm;
        int unsigned g;
        lm = (int'(l) >= 4) ? int'(l) - 8 : int'(l);
        g  = (lm >= 0) ? (32'd1 << lm) : 32'd1;
        return ((idx + g) > 32) || ((idx % g) != 0);
    endfunction

    function automatic int sel_of(input logic g1, input logic g2, input logic gd);
        if (g1) return 0;
        if (g2) return 1;
        if (gd) return 2;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model for the current cycle.
    task automatic chk(input string tag);
        int s;
        logic [31:0] ea;
        #1;
        s  = sel_of(get_rs1_i, get_rs2_i, get_rd_i);
        ea = (m_cnt == RDY && s >= 0) ? m_ptr[s] : 32'd0;
        check({tag, "_ready"}, {31'd0, ready_o}, (m_cnt == RDY) ? 32'd1 : 32'd0);
        check({tag, "_addr"}, vrf_addr_o, ea);
        if (m_cnt == RDY)
            check({tag, "_err"}, {31'd0, range_err_o}, {31'd0, m_err});
        else if (m_cnt <= 0)
            check({tag, "_err"}, {31'd0, range_err_o}, 32'd0);
    endtask

    // Advance the model by the clock edge about to happen, then step past it.
    task automatic cyc();
        int s;
        s = sel_of(get_rs1_i, get_rs2_i, get_rd_i);
        if (rst_ni) begin
            if (load_i) begin
                m_idx[0] = rs1_idx_i; m_idx[1] = rs2_idx_i; m_idx[2] = rd_idx_i;
                m_lmul = lmul_i;
                m_cnt  = 0;
                m_err  = 1'b0;
            end else if (m_cnt >= 0 && m_cnt < RDY) begin
                m_cnt++;
                if (m_cnt == RDY) begin
                    for (int k = 0; k < 3; k++) m_ptr[k] = BASE + m_idx[k] * REG_BYTES;
                    m_err = CHK_EN && (grp_bad(m_idx[0], m_lmul) || grp_bad(m_idx[1], m_lmul) ||
                                       grp_bad(m_idx[2], m_lmul));
                end
            end else if (m_cnt == RDY && incr_i && s >= 0) begin
                m_ptr[s] = m_ptr[s] + STEP;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic gets(input logic g1, input logic g2, input logic gd, input logic inc);
        get_rs1_i = g1; get_rs2_i = g2; get_rd_i = gd; incr_i = inc;
    endtask

    task automatic do_load(input int r1, input int r2, input int rd, input vlmul_e l);
        load_i = 1'b1;
        rs1_idx_i = AW'(r1); rs2_idx_i = AW'(r2); rd_idx_i = AW'(rd); lmul_i = l;
        cyc();
        load_i = 1'b0;
        repeat (RDY) cyc();
    endtask

    initial begin
        rst_ni = 1'b0; load_i = 1'b0;
        rs1_idx_i = '0; rs2_idx_i = '0; rd_idx_i = '0; lmul_i = LMUL_1;
        gets(1'b1, 1'b1, 1'b1, 1'b0);
        m_cnt = -1; m_err = 1'b0; m_lmul = LMUL_1;
        for (int k = 0; k < 3; k++) begin m_ptr[k] = 0; m_idx[k] = 0; end
        #2;
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_addr", vrf_addr_o, 32'd0);
        check("rst_err", {31'd0, range_err_o}, 32'd0);
        repeat (2) cyc();
        rst_ni = 1'b1;
        cyc();
        chk("idle");

        // Load latency and the three basic pointers.
        gets(1'b0, 1'b0, 1'b0, 1'b0);
        load_i = 1'b1; rs1_idx_i = 5'd2; rs2_idx_i = 5'd3; rd_idx_i = 5'd1; lmul_i = LMUL_1;
        cyc();
        load_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lat");
            check("lat_not_ready", {31'd0, ready_o}, 32'd0);
            cyc();
        end
        check("lat_ready_c4", {31'd0, ready_o}, 32'd1);
        gets(1'b1, 1'b0, 1'b0, 1'b0); #1 check("plan_rs1", vrf_addr_o, 32'h20);
        gets(1'b0, 1'b1, 1'b0, 1'b0); #1 check("plan_rs2", vrf_addr_o, 32'h30);
        gets(1'b0, 1'b0, 1'b1, 1'b0); #1 check("plan_rd", vrf_addr_o, 32'h10);

        // Walk rd by one datapath word per cycle.
        gets(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 check("rd_walk", vrf_addr_o, 32'h10 + 32'(4 * i));
            chk("rd_walk_m");
            cyc();
        end
        gets(1'b1, 1'b0, 1'b0, 1'b0); #1 check("rs1_hold", vrf_addr_o, 32'h20);

        // incr with no get is ignored; priority rs2 over rd.
        gets(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc();
        gets(1'b0, 1'b0, 1'b1, 1'b0); #1 check("noget_rd", vrf_addr_o, 32'h20);
        gets(1'b0, 1'b1, 1'b1, 1'b1); #1 check("prio_rs2", vrf_addr_o, 32'h30);
        cyc();
        gets(1'b0, 1'b0, 1'b1, 1'b0); #1 check("prio_rd_kept", vrf_addr_o, 32'h20);
        gets(1'b0, 1'b1, 1'b0, 1'b0); #1 check("prio_rs2_inc", vrf_addr_o, 32'h34);

        // incr during CALC states has no effect; rs1 beats rd.
        gets(1'b1, 1'b1, 1'b1, 1'b1);
        load_i = 1'b1; rs1_idx_i = 5'd4; rs2_idx_i = 5'd5; rd_idx_i = 5'd7; lmul_i = LMUL_1;
        cyc();
        load_i = 1'b0;
        repeat (RDY) begin chk("calc_incr"); cyc(); end
        gets(1'b1, 1'b0, 1'b1, 1'b0); #1 check("calc_rs1", vrf_addr_o, 32'h40);
        gets(1'b0, 1'b1, 1'b0, 1'b0); #1 check("calc_rs2", vrf_addr_o, 32'h50);
        gets(1'b0, 1'b0, 1'b1, 1'b0); #1 check("calc_rd", vrf_addr_o, 32'h70);

        // Group range and alignment checks with LMUL=4.
        gets(1'b0, 1'b0, 1'b0, 1'b0);
        do_load(0, 4, 30, LMUL_4);
        check("err_rd30", {31'd0, range_err_o}, {31'd0, CHK_EN});
        chk("err_rd30_m");
        do_load(0, 4, 8, LMUL_4);
        check("err_rd8", {31'd0, range_err_o}, 32'd0);
        do_load(0, 4, 6, LMUL_4);
        check("err_rd6", {31'd0, range_err_o}, {31'd0, CHK_EN});
        do_load(3, 5, 31, LMUL_F2);
        check("err_frac", {31'd0, range_err_o}, 32'd0);

        // Restart from CALC_RS2 with new indices.
        load_i = 1'b1; rs1_idx_i = 5'd2; rs2_idx_i = 5'd3; rd_idx_i = 5'd1; lmul_i = LMUL_1;
        cyc();
        load_i = 1'b0;
        cyc();
        load_i = 1'b1; rs1_idx_i = 5'd9; rs2_idx_i = 5'd10; rd_idx_i = 5'd11;
        cyc();
        load_i = 1'b0;
        repeat (RDY) begin
            check("restart_not_ready", {31'd0, ready_o}, 32'd0);
            cyc();
        end
        check("restart_ready", {31'd0, ready_o}, 32'd1);
        gets(1'b1, 1'b0, 1'b0, 1'b0); #1 check("restart_rs1", vrf_addr_o, 32'h90);
        gets(1'b0, 1'b1, 1'b0, 1'b0); #1 check("restart_rs2", vrf_addr_o, 32'hA0);
        gets(1'b0, 1'b0, 1'b1, 1'b0); #1 check("restart_rd", vrf_addr_o, 32'hB0);
        cyc();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            load_i    = ($urandom_range(0, 7) == 0);
            rs1_idx_i = AW'($urandom_range(0, 31));
            rs2_idx_i = AW'($urandom_range(0, 31));
            rd_idx_i  = AW'($urandom_range(0, 31));
            lmul_i    = vlmul_e'(3'($urandom_range(0, 7)));
            gets(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("rand");
            cyc();
        end
        load_i = 1'b0;

        // Asynchronous reset while READY.
        gets(1'b0, 1'b0, 1'b0, 1'b0);
        do_load(1, 2, 3, LMUL_1);
        check("pre_rst_ready", {31'd0, ready_o}, 32'd1);
        gets(1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst_ni = 1'b0;
        m_cnt = -1; m_err = 1'b0;
        #1;
        check("arst_ready", {31'd0, ready_o}, 32'd0);
        check("arst_addr", vrf_addr_o, 32'd0);
        cyc();
        rst_ni = 1'b1;
        repeat (5) begin chk("post_rst_idle"); cyc(); end
        do_load(6, 7, 8, LMUL_2);
        chk("post_rst_load");
        check("post_rst_rs1", vrf_addr_o, 32'h60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
